// File: rtl/mipi_raw_unpacker.sv
// CSI-2 payload byte-to-pixel unpacker for RAW8 / RAW10 / RAW12.
// Takes LANES payload bytes per beat (lane 0 earliest) and emits groups of
// four MSB-aligned 12-bit pixels. The format is latched on each frame start.
// Lines that end with bytes still buffered are flagged.

module mipi_raw_unpacker #(
  parameter int LANES = 2
) (
  input  logic               sclk,
  input  logic               s_rst_n,
  input  logic               raw_vld,
  input  logic [8*LANES-1:0] raw_data,
  input  logic               raw_vsync,
  input  logic               raw_eol,
  input  logic [1:0]         raw_mode,
  output logic               pixel_vld,
  output logic [47:0]        pixel_data,
  output logic               align_err
);

  typedef enum logic [1:0] {
    RAW8  = 2'b00,
    RAW10 = 2'b01,
    RAW12 = 2'b10,
    RSVD  = 2'b11
  } mode_t;

  mode_t       mode_q;
  logic        frame_valid;
  logic [3:0]  cnt_q;
  logic [7:0]  buf_q [0:5];

  logic [3:0]  grp_size;
  logic [3:0]  total;
  logic [3:0]  cnt_post;
  logic [3:0]  cnt_d;
  logic        accept;
  logic        grp_done;
  logic        eol_err;
  logic [7:0]  comb [0:15];
  logic [7:0]  buf_d [0:5];
  logic [47:0] pix;

  // Group size in bytes for the latched format
  always_comb begin
    grp_size = 4'd6;
    case (mode_q)
      RAW8:    grp_size = 4'd4;
      RAW10:   grp_size = 4'd5;
      default: grp_size = 4'd6;
    endcase
  end

  // Beat acceptance, group completion and post-beat byte count
  always_comb begin
    accept   = frame_valid && raw_vld && !raw_vsync && (mode_q != RSVD);
    total    = cnt_q + 4'(LANES);
    grp_done = accept && (total >= grp_size);
    if (grp_done)
      cnt_post = total - grp_size;
    else if (accept)
      cnt_post = total;
    else
      cnt_post = cnt_q;
    eol_err = frame_valid && raw_eol && !raw_vsync && (cnt_post != 4'd0);
    if (raw_vsync || eol_err)
      cnt_d = 4'd0;
    else
      cnt_d = cnt_post;
  end

  // Residual bytes followed by the new beat's bytes, then the shifted remainder
  always_comb begin
    for (int i = 0; i < 16; i++)
      comb[i] = 8'h00;
    for (int i = 0; i < 6; i++)
      comb[i] = buf_q[i];
    for (int k = 0; k < LANES; k++)
      comb[cnt_q + 4'(k)] = raw_data[8*k +: 8];
    for (int j = 0; j < 6; j++)
      buf_d[j] = grp_done ? comb[4'(j) + grp_size] : comb[j];
  end

  // Pixel extraction from the first group bytes
  always_comb begin
    pix = 48'h0;
    case (mode_q)
      RAW8:  pix = {comb[0], 4'h0, comb[1], 4'h0, comb[2], 4'h0, comb[3], 4'h0};
      RAW10: pix = {comb[0], comb[4][1:0], 2'b00, comb[1], comb[4][3:2], 2'b00,
                    comb[2], comb[4][5:4], 2'b00, comb[3], comb[4][7:6], 2'b00};
      RAW12: pix = {comb[0], comb[2][3:0], comb[1], comb[2][7:4],
                    comb[3], comb[5][3:0], comb[4], comb[5][7:4]};
      default: pix = 48'h0;
    endcase
  end

  // Registered state and outputs; pixel_data holds between groups
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      pixel_vld   <= 1'b0;
      pixel_data  <= 48'h0;
      align_err   <= 1'b0;
      frame_valid <= 1'b0;
      cnt_q       <= 4'd0;
      mode_q      <= RAW8;
      for (int i = 0; i < 6; i++)
        buf_q[i] <= 8'h00;
    end else begin
      pixel_vld <= grp_done;
      align_err <= eol_err;
      cnt_q     <= cnt_d;
      if (grp_done)
        pixel_data <= pix;
      if (accept)
        for (int i = 0; i < 6; i++)
          buf_q[i] <= buf_d[i];
      if (raw_vsync) begin
        frame_valid <= 1'b1;
        mode_q      <= mode_t'(raw_mode);
      end
    end
  end

endmodule
